// File: rtl/s1_mem_pkg.sv
// Shared decode constants and types for the S1 data-side memory responder.
package s1_mem_pkg;

    // Address bit that steers an access into the MMIO window
    localparam int unsigned MMIO_SEL_BIT = 29;

    // MMIO word offsets, decoded on data_addr[1:0]
    localparam logic [1:0] MMIO_OUT    = 2'd0;
    localparam logic [1:0] MMIO_CYCLES = 2'd1;
    localparam logic [1:0] MMIO_HALT   = 2'd2;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_BAD
    } mem_region_t;

    // MMIO wins over the range check; RAM only when the high word bits are clear
    function automatic mem_region_t decode_region(input logic mmio_sel, input logic in_range);
        if (mmio_sel) begin
            return REG_MMIO;
        end
        return in_range ? REG_RAM : REG_BAD;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Word RAM built from four byte-lane arrays: masked synchronous write, registered read.
module byte_ram #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_q;

        // Per-lane write when enabled; read data only moves on a read request
        always_ff @(posedge clk) begin
            if (we[lane]) begin
                mem[addr] <= wdata[8*lane +: 8];
            end
            if (re) begin
                rdata_q <= mem[addr];
            end
        end

        assign rdata[8*lane +: 8] = rdata_q;
    end

endmodule

// File: rtl/tb_data_mem.sv
// Data-side responder for the S1 CPU: byte-maskable RAM plus console/cycles/halt MMIO.
module tb_data_mem #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mask,
    input  logic [29:0] data_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        halt,
    output logic        addr_err
);

    import s1_mem_pkg::*;

    logic        accept;
    logic        is_read;
    logic        is_write;
    logic        in_range;
    logic [1:0]  mmio_off;
    mem_region_t region;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;
    logic        out_wr;
    logic        halt_wr;

    logic [31:0] cycles_q;
    logic [31:0] out_data_q;
    logic        out_valid_q;
    logic        halt_q;
    logic        err_q;
    logic        rd_ram_q;   // last accepted read came from RAM
    logic [31:0] rd_reg_q;   // MMIO/zero result of the last non-RAM read

    assign accept   = clk_en & mem_req;
    assign is_read  = accept & ~mem_we;
    assign is_write = accept & mem_we;
    assign in_range = (data_addr[28:DEPTH_LOG2] == '0);
    assign mmio_off = data_addr[1:0];
    assign region   = decode_region(data_addr[MMIO_SEL_BIT], in_range);

    assign ram_we  = (is_write && region == REG_RAM) ? mask : 4'b0000;
    assign ram_re  = is_read && region == REG_RAM;
    assign out_wr  = is_write && region == REG_MMIO && mmio_off == MMIO_OUT && mask != 4'b0000;
    assign halt_wr = is_write && region == REG_MMIO && mmio_off == MMIO_HALT && mask != 4'b0000;

    // MMIO read value; the reserved offset reads as zero
    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            MMIO_OUT:    mmio_rdata = out_data_q;
            MMIO_CYCLES: mmio_rdata = cycles_q;
            MMIO_HALT:   mmio_rdata = {31'b0, halt_q};
            default:     mmio_rdata = '0;
        endcase
    end

    byte_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (data_addr[DEPTH_LOG2-1:0]),
        .wdata (data_out),
        .rdata (ram_rdata)
    );

    // Free-running cycle counter, advancing only on enabled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else if (clk_en) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    // MMIO registers, sticky flags and read-source select aligned with the RAM output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_ram_q    <= 1'b0;
            rd_reg_q    <= '0;
        end else if (clk_en) begin
            out_valid_q <= out_wr;
            if (out_wr) begin
                out_data_q <= data_out;
            end
            if (halt_wr) begin
                halt_q <= 1'b1;
            end
            if (accept && region == REG_BAD) begin
                err_q <= 1'b1;
            end
            if (is_read) begin
                rd_ram_q <= (region == REG_RAM);
                rd_reg_q <= (region == REG_MMIO) ? mmio_rdata : '0;
            end
        end else begin
            // The console strobe never stretches across stalled cycles
            out_valid_q <= 1'b0;
        end
    end

    assign data_in   = rd_ram_q ? ram_rdata : rd_reg_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halt      = halt_q;
    assign addr_err  = err_q;

endmodule

// File: tb/tb_tb_data_mem.sv
// Self-checking bench for tb_data_mem: directed scenarios plus randomized RAM/console traffic.
module tb_tb_data_mem;

    localparam logic [29:0] A_OUT    = 30'h2000_0000;
    localparam logic [29:0] A_CYCLES = 30'h2000_0001;
    localparam logic [29:0] A_HALT   = 30'h2000_0002;
    localparam logic [29:0] A_RSVD   = 30'h2000_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mask = 4'b0000;
    logic [29:0] data_addr = '0;
    logic [31:0] data_out = '0;
    logic [31:0] data_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        halt;
    logic        addr_err;

    int total = 0;
    int bad = 0;

    // Reference RAM image and console value
    logic [31:0] model [256];
    logic [31:0] model_out = '0;

    tb_data_mem #(
        .DEPTH_LOG2(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mask      (mask),
        .data_addr (data_addr),
        .data_out  (data_out),
        .data_in   (data_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halt      (halt),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    // Called at a negedge: present one request, return at the next negedge with it cleared
    task automatic access(input logic we, input logic [3:0] m, input logic [29:0] a,
                          input logic [31:0] wd);
        mem_req   = 1'b1;
        mem_we    = we;
        mask      = m;
        data_addr = a;
        data_out  = wd;
        @(negedge clk);
        mem_req = 1'b0;
        mem_we  = 1'b0;
    endtask

    task automatic model_write(input logic [3:0] m, input int a, input logic [31:0] wd);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) model[a][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (data_in !== 32'h0) begin bad++; $display("FAIL reset_data_in got %h want 0", data_in); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got %b want 0", halt); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst = 1'b1;
        access(1'b0, 4'hF, A_CYCLES, '0);
        total++; if (data_in > 32'd4) begin bad++; $display("FAIL reset_cycles got %0d want <=4", data_in); end
        // Give the RAM a known image so every later read has a defined expectation
        for (int i = 0; i < 256; i++) begin
            access(1'b1, 4'hF, 30'(i), 32'h0);
            model[i] = 32'h0;
        end
    endtask

    task automatic test_full_rw();
        access(1'b1, 4'hF, 30'd4, 32'hDEAD_BEEF);
        model_write(4'hF, 4, 32'hDEAD_BEEF);
        access(1'b0, 4'hF, 30'd4, '0);
        total++; if (data_in !== 32'hDEAD_BEEF) begin bad++; $display("FAIL full_read got %h want deadbeef", data_in); end
        access(1'b1, 4'hF, 30'd5, 32'h1111_2222);
        model_write(4'hF, 5, 32'h1111_2222);
        total++; if (data_in !== 32'hDEAD_BEEF) begin bad++; $display("FAIL write_holds_data_in got %h want deadbeef", data_in); end
    endtask

    task automatic test_byte_mask();
        access(1'b1, 4'b0010, 30'd4, 32'h0000_AA00);
        model_write(4'b0010, 4, 32'h0000_AA00);
        access(1'b0, 4'b0000, 30'd4, '0);
        total++; if (data_in !== 32'hDEAD_AAEF) begin bad++; $display("FAIL byte_mask got %h want deadaaef", data_in); end
        access(1'b1, 4'b0000, 30'd4, 32'h1234_5678);
        access(1'b0, 4'b1111, 30'd4, '0);
        total++; if (data_in !== 32'hDEAD_AAEF) begin bad++; $display("FAIL mask_zero got %h want deadaaef", data_in); end
    endtask

    task automatic test_clk_en();
        logic [31:0] c0;
        access(1'b0, 4'hF, A_CYCLES, '0);
        c0 = data_in;
        clk_en = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mask = 4'hF; data_addr = 30'd4; data_out = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        mem_req = 1'b0; mem_we = 1'b0;
        total++; if (data_in !== c0) begin bad++; $display("FAIL gated_data_in got %h want %h", data_in, c0); end
        clk_en = 1'b1;
        access(1'b0, 4'hF, A_CYCLES, '0);
        total++; if (data_in - c0 !== 32'd1) begin bad++; $display("FAIL gated_cycles got %0d want %0d", data_in, c0 + 1); end
        access(1'b0, 4'hF, 30'd4, '0);
        total++; if (data_in !== 32'hDEAD_AAEF) begin bad++; $display("FAIL gated_ram got %h want deadaaef", data_in); end
    endtask

    task automatic test_mmio();
        access(1'b1, 4'b0001, A_OUT, 32'h0000_002A);
        model_out = 32'h2A;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL out_valid_pulse got %b want 1", out_valid); end
        total++; if (out_data !== 32'h2A) begin bad++; $display("FAIL out_data got %h want 2a", out_data); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL out_valid_drop got %b want 0", out_valid); end
        access(1'b0, 4'hF, A_OUT, '0);
        total++; if (data_in !== 32'h2A) begin bad++; $display("FAIL out_read got %h want 2a", data_in); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_early got %b want 0", halt); end
        access(1'b1, 4'b0100, A_HALT, 32'h0);
        repeat (3) @(negedge clk);
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_sticky got %b want 1", halt); end
        access(1'b0, 4'hF, A_HALT, '0);
        total++; if (data_in !== 32'h1) begin bad++; $display("FAIL halt_read got %h want 1", data_in); end
        access(1'b1, 4'hF, A_RSVD, 32'hFFFF_FFFF);
        access(1'b0, 4'hF, A_RSVD, '0);
        total++; if (data_in !== 32'h0) begin bad++; $display("FAIL rsvd_read got %h want 0", data_in); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rsvd_addr_err got %b want 0", addr_err); end
    endtask

    task automatic test_random();
        logic [31:0] exp_din;
        logic [31:0] wd;
        logic [3:0]  m;
        int          a;
        int          r;
        exp_din = data_in;
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            a  = $urandom_range(0, 31);
            wd = $urandom;
            m  = 4'($urandom_range(0, 15));
            if (r < 4) begin
                access(1'b1, m, 30'(a), wd);
                model_write(m, a, wd);
                total++; if (data_in !== exp_din) begin bad++; $display("FAIL rnd_write_hold got %h want %h", data_in, exp_din); end
            end else if (r < 8) begin
                access(1'b0, m, 30'(a), '0);
                exp_din = model[a];
                total++; if (data_in !== exp_din) begin bad++; $display("FAIL rnd_read a=%0d got %h want %h", a, data_in, exp_din); end
            end else if (r == 8) begin
                if (m == 4'b0000) m = 4'b1000;
                access(1'b1, m, A_OUT, wd);
                model_out = wd;
                total++; if (out_valid !== 1'b1 || out_data !== model_out) begin
                    bad++; $display("FAIL rnd_out got %b/%h want 1/%h", out_valid, out_data, model_out);
                end
            end else begin
                @(negedge clk);
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle_valid got %b want 0", out_valid); end
            end
        end
    endtask

    task automatic test_range();
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL pre_range_err got %b want 0", addr_err); end
        access(1'b1, 4'hF, 30'h100, 32'hCAFE_F00D);
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL range_write_err got %b want 1", addr_err); end
        access(1'b0, 4'hF, 30'd0, '0);
        total++; if (data_in !== model[0]) begin bad++; $display("FAIL range_word0 got %h want %h", data_in, model[0]); end
        access(1'b1, 4'hF, 30'd4, 32'hDEAD_AAEF);
        model_write(4'hF, 4, 32'hDEAD_AAEF);
        access(1'b0, 4'hF, 30'd4, '0);
        access(1'b0, 4'hF, 30'h100, '0);
        total++; if (data_in !== 32'h0) begin bad++; $display("FAIL range_read got %h want 0", data_in); end
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL range_err_sticky got %b want 1", addr_err); end
    endtask

    task automatic test_reset_mid_read();
        access(1'b0, 4'hF, 30'd4, '0);
        total++; if (data_in !== 32'hDEAD_AAEF) begin bad++; $display("FAIL pre_reset_read got %h want deadaaef", data_in); end
        mem_req = 1'b1; mem_we = 1'b0; mask = 4'hF; data_addr = 30'd5;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (data_in !== 32'h0) begin bad++; $display("FAIL mid_reset_data_in got %h want 0", data_in); end
        total++; if (halt !== 1'b0 || addr_err !== 1'b0) begin
            bad++; $display("FAIL mid_reset_flags got %b%b want 00", halt, addr_err);
        end
        mem_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 4'hF, 30'd4, '0);
        total++; if (data_in !== 32'hDEAD_AAEF) begin bad++; $display("FAIL ram_kept got %h want deadaaef", data_in); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_rw();
        test_byte_mask();
        test_clk_en();
        test_mmio();
        test_random();
        test_range();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
